// File: rtl/tdm_demux_8.sv
// tdm_demux_8: receive end of an 8-slot TDM serial link.
// Finds frame alignment from the slot-0 sync marker, tracks it, and
// presents each completed frame as an 8-bit word with a one-cycle valid.
//
// Slot handshake: a "slot event" is a rising clk edge with en=1. There is
// no back-pressure; every slot event is consumed. sync/din are ignored on
// cycles with en=0, and no state changes without a slot event.
//
// Alignment states:
//   HUNT    - waiting for any sync; slot counter held at 0
//   ACQUIRE - aligned but fewer than LOCK_FRAMES consecutive good syncs
//   LOCKED  - frames are delivered on the slot-7 event
// The current state is exposed on dbg_state for observation.
module tdm_demux_8 #(
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sync,
  input  logic       din,
  output logic [7:0] dout,
  output logic [2:0] sel,
  output logic       frame_vld,
  output logic       locked,
  output logic       sync_err,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Lock threshold in the width of the good-sync counter.
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  // State reached on a fresh alignment (HUNT sync or early-sync realign).
  localparam state_t ST_ALIGNED = (LOCK_N == 4'd1) ? ST_LOCKED : ST_ACQUIRE;

  // Reset synchroniser: assertion is immediate, release is aligned to clk.
  logic [1:0] r_rst_pipe;
  logic       w_rst_n;

  // Registered state and datapath.
  state_t     r_state;
  logic [2:0] r_cnt;
  logic [3:0] r_good;
  logic [6:0] r_buf;     // slots 0..6 of the frame in progress
  logic [7:0] r_dout;
  logic       r_vld;
  logic       r_locked;
  logic       r_err;

  // Next-state values.
  state_t     w_state_nxt;
  logic [2:0] w_cnt_nxt;
  logic [3:0] w_good_nxt;
  logic [6:0] w_buf_nxt;
  logic [7:0] w_dout_nxt;
  logic       w_vld_nxt;
  logic       w_err_nxt;

  // Decoded slot conditions.
  logic       w_slot0;
  logic       w_slot7;
  logic [3:0] w_good_inc;

  // Two-flop reset release synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_pipe <= 2'b00;
    end else begin
      r_rst_pipe <= {r_rst_pipe[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_pipe[1];

  assign w_slot0    = (r_cnt == 3'd0);
  assign w_slot7    = (r_cnt == 3'd7);
  assign w_good_inc = (r_good == 4'hF) ? 4'hF : (r_good + 4'd1);

  // Next-state, counter, capture and delivery decisions for one slot event.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_good_nxt  = r_good;
    w_buf_nxt   = r_buf;
    w_dout_nxt  = r_dout;
    w_vld_nxt   = 1'b0;
    w_err_nxt   = 1'b0;

    if (en) begin
      case (r_state)
        ST_HUNT: begin
          // Any sync marks slot 0 of a new frame.
          if (sync) begin
            w_buf_nxt   = {6'b0, din};
            w_cnt_nxt   = 3'd1;
            w_good_nxt  = 4'd1;
            w_state_nxt = ST_ALIGNED;
          end
        end

        ST_ACQUIRE, ST_LOCKED: begin
          if (w_slot0 && !sync) begin
            // Missing sync: alignment lost, start hunting again.
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_HUNT;
            w_cnt_nxt   = 3'd0;
            w_good_nxt  = 4'd0;
          end else if (!w_slot0 && sync) begin
            // Early sync: trust the new marker, drop the partial frame.
            w_err_nxt   = 1'b1;
            w_buf_nxt   = {6'b0, din};
            w_cnt_nxt   = 3'd1;
            w_good_nxt  = 4'd1;
            w_state_nxt = ST_ALIGNED;
          end else if (w_slot0) begin
            // Good sync: this bit is slot 0 of the next frame.
            w_buf_nxt[0] = din;
            w_cnt_nxt    = 3'd1;
            w_good_nxt   = w_good_inc;
            if (w_good_inc >= LOCK_N) begin
              w_state_nxt = ST_LOCKED;
            end
          end else if (w_slot7) begin
            // Last slot: deliver only when locked.
            w_cnt_nxt = 3'd0;
            if (r_state == ST_LOCKED) begin
              w_dout_nxt = {din, r_buf};
              w_vld_nxt  = 1'b1;
            end
          end else begin
            // Ordinary data slot 1..6.
            for (int k = 1; k < 7; k++) begin
              if (r_cnt == 3'(k)) begin
                w_buf_nxt[k] = din;
              end
            end
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end

        default: begin
          w_state_nxt = ST_HUNT;
          w_cnt_nxt   = 3'd0;
          w_good_nxt  = 4'd0;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt    <= 3'd0;
      r_good   <= 4'd0;
      r_buf    <= 7'd0;
      r_dout   <= 8'd0;
      r_vld    <= 1'b0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_good   <= w_good_nxt;
      r_buf    <= w_buf_nxt;
      r_dout   <= w_dout_nxt;
      r_vld    <= w_vld_nxt;
      r_locked <= (w_state_nxt == ST_LOCKED);
      r_err    <= w_err_nxt;
    end
  end

  assign dout      = r_dout;
  assign sel       = r_cnt;
  assign frame_vld = r_vld;
  assign locked    = r_locked;
  assign sync_err  = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tdm_demux_8.sv
// Directed bench for tdm_demux_8: one instance with LOCK_FRAMES=2 and one
// with LOCK_FRAMES=1, sharing clock, reset and link inputs.
module tb_tdm_demux_8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic sync = 1'b0;
  logic din = 1'b0;

  logic [7:0] a_dout, b_dout;
  logic [2:0] a_sel, b_sel;
  logic       a_vld, b_vld;
  logic       a_locked, b_locked;
  logic       a_err, b_err;
  logic [1:0] a_state, b_state;

  int checks = 0;
  int errors = 0;
  int gap = 0;

  // Clock
  always #5 clk = ~clk;

  tdm_demux_8 #(.LOCK_FRAMES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .din(din),
    .dout(a_dout), .sel(a_sel), .frame_vld(a_vld), .locked(a_locked),
    .sync_err(a_err), .dbg_state(a_state)
  );

  tdm_demux_8 #(.LOCK_FRAMES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .din(din),
    .dout(b_dout), .sel(b_sel), .frame_vld(b_vld), .locked(b_locked),
    .sync_err(b_err), .dbg_state(b_state)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      en = 1'b0; sync = 1'b0; din = 1'b0;
      tick();
    end
  endtask

  // One slot event, preceded by `gap` en=0 cycles carrying random junk.
  task automatic slot(input logic s, input logic d);
    for (int g = 0; g < gap; g++) begin
      en   = 1'b0;
      sync = 1'($urandom_range(0, 1));
      din  = 1'($urandom_range(0, 1));
      tick();
    end
    en = 1'b1; sync = s; din = d;
    tick();
    en = 1'b0; sync = 1'b0; din = 1'b0;
  endtask

  // Send slots first..last of byte b; s0 is the sync value at slot 0.
  task automatic send_bits(input logic [7:0] b, input int first, input int last, input logic s0);
    for (int k = first; k <= last; k++) begin
      slot((k == 0) ? s0 : 1'b0, b[k]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
  endtask

  initial begin
    tick();
    do_reset();

    // Reset state
    check("rst_dout",   a_dout, 8'h00);
    check("rst_sel",    {5'b0, a_sel}, 8'h00);
    check("rst_vld",    {7'b0, a_vld}, 8'h00);
    check("rst_locked", {7'b0, a_locked}, 8'h00);
    check("rst_err",    {7'b0, a_err}, 8'h00);
    check("rst_state",  {6'b0, a_state}, 8'h00);
    check("rst_b_lock", {7'b0, b_locked}, 8'h00);

    // LOCK_FRAMES=1: lock on first sync, first frame delivered
    send_bits(8'h7E, 0, 0, 1'b1);
    check("lf1_locked",   {7'b0, b_locked}, 8'h01);
    check("lf2_not_lock", {7'b0, a_locked}, 8'h00);
    check("lf2_acq",      {6'b0, a_state}, 8'h01);
    check("lf2_sel",      {5'b0, a_sel}, 8'h01);
    send_bits(8'h7E, 1, 7, 1'b1);
    check("lf1_vld",   {7'b0, b_vld}, 8'h01);
    check("lf1_dout",  b_dout, 8'h7E);
    check("lf2_novld", {7'b0, a_vld}, 8'h00);
    check("lf2_dout0", a_dout, 8'h00);
    idle(1);
    check("lf1_vld_w", {7'b0, b_vld}, 8'h00);
    check("lf1_hold",  b_dout, 8'h7E);

    // Continuous frames A5, 3C, 81
    do_reset();
    send_bits(8'hA5, 0, 7, 1'b1);
    check("c_a5_novld", {7'b0, a_vld}, 8'h00);
    check("c_a5_nolck", {7'b0, a_locked}, 8'h00);
    send_bits(8'h3C, 0, 0, 1'b1);
    check("c_3c_lock", {7'b0, a_locked}, 8'h01);
    send_bits(8'h3C, 1, 7, 1'b1);
    check("c_3c_vld",  {7'b0, a_vld}, 8'h01);
    check("c_3c_dout", a_dout, 8'h3C);
    check("c_sel_wrap", {5'b0, a_sel}, 8'h00);
    send_bits(8'h81, 0, 0, 1'b1);
    check("c_vld_1cyc", {7'b0, a_vld}, 8'h00);
    check("c_3c_hold",  a_dout, 8'h3C);
    send_bits(8'h81, 1, 7, 1'b1);
    check("c_81_vld",  {7'b0, a_vld}, 8'h01);
    check("c_81_dout", a_dout, 8'h81);

    // Same frames with en high 1 cycle in 3
    do_reset();
    gap = 2;
    send_bits(8'hA5, 0, 7, 1'b1);
    check("g_a5_novld", {7'b0, a_vld}, 8'h00);
    send_bits(8'h3C, 0, 0, 1'b1);
    check("g_3c_lock", {7'b0, a_locked}, 8'h01);
    send_bits(8'h3C, 1, 7, 1'b1);
    check("g_3c_vld",  {7'b0, a_vld}, 8'h01);
    check("g_3c_dout", a_dout, 8'h3C);
    idle(1);
    check("g_vld_1cyc", {7'b0, a_vld}, 8'h00);
    check("g_sel_hold", {5'b0, a_sel}, 8'h00);
    send_bits(8'h81, 0, 7, 1'b1);
    check("g_81_vld",  {7'b0, a_vld}, 8'h01);
    check("g_81_dout", a_dout, 8'h81);
    idle(1);
    check("g_81_1cyc", {7'b0, a_vld}, 8'h00);
    check("g_81_hold", a_dout, 8'h81);
    gap = 0;

    // Missing sync while locked
    send_bits(8'h00, 0, 0, 1'b0);
    check("m_err",    {7'b0, a_err}, 8'h01);
    check("m_unlock", {7'b0, a_locked}, 8'h00);
    check("m_hunt",   {6'b0, a_state}, 8'h00);
    send_bits(8'h00, 1, 1, 1'b0);
    check("m_err_1cyc", {7'b0, a_err}, 8'h00);
    send_bits(8'h00, 2, 7, 1'b0);
    check("m_novld", {7'b0, a_vld}, 8'h00);
    check("m_hold",  a_dout, 8'h81);
    send_bits(8'h11, 0, 7, 1'b1);
    check("m_11_novld", {7'b0, a_vld}, 8'h00);
    check("m_11_nolck", {7'b0, a_locked}, 8'h00);
    send_bits(8'h22, 0, 0, 1'b1);
    check("m_22_lock", {7'b0, a_locked}, 8'h01);
    send_bits(8'h22, 1, 7, 1'b1);
    check("m_22_vld",  {7'b0, a_vld}, 8'h01);
    check("m_22_dout", a_dout, 8'h22);

    // Early sync at slot 5 while locked
    send_bits(8'hFF, 0, 4, 1'b1);
    check("e_no_err", {7'b0, a_err}, 8'h00);
    slot(1'b1, 1'b1);
    check("e_err",    {7'b0, a_err}, 8'h01);
    check("e_sel",    {5'b0, a_sel}, 8'h01);
    check("e_unlock", {7'b0, a_locked}, 8'h00);
    check("e_acq",    {6'b0, a_state}, 8'h01);
    send_bits(8'h00, 1, 7, 1'b0);
    check("e_novld", {7'b0, a_vld}, 8'h00);
    check("e_hold",  a_dout, 8'h22);
    check("e_sel0",  {5'b0, a_sel}, 8'h00);
    send_bits(8'hF0, 0, 0, 1'b1);
    check("e_relock", {7'b0, a_locked}, 8'h01);
    check("e_err_clr", {7'b0, a_err}, 8'h00);
    send_bits(8'hF0, 1, 7, 1'b1);
    check("e_f0_vld",  {7'b0, a_vld}, 8'h01);
    check("e_f0_dout", a_dout, 8'hF0);

    // Asynchronous reset mid-frame while locked
    send_bits(8'h99, 0, 3, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_dout",   a_dout, 8'h00);
    check("ar_sel",    {5'b0, a_sel}, 8'h00);
    check("ar_vld",    {7'b0, a_vld}, 8'h00);
    check("ar_locked", {7'b0, a_locked}, 8'h00);
    check("ar_err",    {7'b0, a_err}, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    send_bits(8'h5A, 0, 7, 1'b1);
    check("ar_5a_novld", {7'b0, a_vld}, 8'h00);
    check("ar_5a_dout0", a_dout, 8'h00);
    send_bits(8'h5A, 0, 0, 1'b1);
    check("ar_5a_lock", {7'b0, a_locked}, 8'h01);
    send_bits(8'h5A, 1, 7, 1'b1);
    check("ar_5a_vld",  {7'b0, a_vld}, 8'h01);
    check("ar_5a_dout", a_dout, 8'h5A);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux_8.md
# tdm_demux_8

Eight-slot time-division demultiplexer: the receive end of the 8:1 slot-multiplexed serial link. Takes one bit per slot strobe plus a frame-sync marker on slot 0, locates and tracks frame alignment, and steers each slot bit to its own output line. Completed frames are presented as an 8-bit word with a single-cycle valid pulse. It sits after the serial link input and feeds per-channel consumers.

## Interface
- LOCK_FRAMES, 2, consecutive correctly placed syncs required to declare lock (legal 1..15)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  slot strobe; `din`/`sync` sampled only when high
- sync  input  1  frame marker, high with the slot-0 bit
- din  input  1  serial slot bit
- dout  output  8  last delivered frame; `dout[k]` = slot k bit
- sel  output  3  index of next expected slot; slot k carries channel k, `sel[2]` is MSB
- frame_vld  output  1  one-cycle pulse, `dout` updated
- locked  output  1  high while in LOCKED
- sync_err  output  1  one-cycle pulse on alignment error in ACQUIRE/LOCKED

## Operation
- Slot event: a rising edge with `en`=1. No state changes without a slot event; `sync`/`din` ignored when `en`=0.
- Slot counter (3-bit, wraps 7→0) advances on every slot event outside HUNT; a capture buffer stores `din` at bit [slot].
- **Good sync**: `sync`=1 at slot 0. **Missing sync**: `sync`=0 at slot 0. **Early sync**: `sync`=1 at slot 1..7.
- States: HUNT, ACQUIRE, LOCKED; `good_cnt` is 4-bit.
- **HUNT**: counter held at 0. Slot event with `sync`=1 → capture bit as slot 0, counter=1, good_cnt=1; go to LOCKED if LOCK_FRAMES=1, else ACQUIRE.
- **ACQUIRE**
  - Good sync → good_cnt+1. Reaching LOCK_FRAMES → LOCKED; the frame starting at that sync is delivered.
  - Missing sync → sync_err, HUNT.
  - Early sync → sync_err, realign: the bit becomes slot 0, counter=1, good_cnt=1.
- **LOCKED**
  - Slot event at slot 7 → `dout` <= {din, buf[6:0]}, frame_vld pulse.
  - Good sync → stay.
  - Missing sync → sync_err, HUNT, `locked` drops.
  - Early sync → sync_err; realign exactly as in ACQUIRE; enter ACQUIRE (LOCKED if LOCK_FRAMES=1). The partial frame is discarded with no frame_vld.
- `dout` holds its value between deliveries and is never cleared except by reset. Frames are not delivered in HUNT/ACQUIRE.
- Sync check takes priority over capture at the same slot event.

## Timing
- All outputs registered.
- Reset (async assert, sync release) gives: state HUNT, counter 0, good_cnt 0, buffer 0, `dout`=0x00, `sel`=0, `frame_vld`=0, `locked`=0, `sync_err`=0.
- Reset mid-frame discards the partial frame. The first post-reset frame needs LOCK_FRAMES good syncs.
- Latency: `dout`/`frame_vld` valid in the cycle after the edge that samples slot 7. `frame_vld` is exactly 1 cycle for any `en` pattern, including `en` held high.
- `locked` and `sync_err` change on the same edge that detects the condition.
- `sel` equals the counter and updates on the slot-event edge.
- Minimum frame = 8 consecutive cycles with `en`=1; back-to-back frames deliver every 8 cycles.

## Test plan
1. Pulse `rst_n` low for 3 cycles mid-frame while LOCKED → all outputs 0 immediately (asynchronous). After release, sending 0x5A needs 2 good syncs before delivery.
2. LOCK_FRAMES=2, `en` continuous, frames 0xA5, 0x3C, 0x81, each with sync at slot 0:
   - 0xA5 → no frame_vld.
   - 0x3C → `locked` rises on its sync edge; frame_vld one cycle after its slot-7 edge; `dout`=0x3C.
   - 0x81 → `dout`=0x81 exactly 8 cycles later.
3. Same frames with `en` high 1 cycle in 3; random `sync`/`din` while `en`=0 → identical `dout` sequence; each frame_vld 1 cycle wide.
4. While LOCKED, frame with `sync`=0 at slot 0 → `sync_err` pulse, `locked`=0, no frame_vld. Next 2 good-sync frames 0x11, 0x22 → only 0x22 delivered.
5. While LOCKED, `sync`=1 at slot 5 → `sync_err`, partial frame dropped, `sel`=1 next. The following good sync relocks; that frame (0xF0) is delivered.
6. LOCK_FRAMES=1: first sync from HUNT → `locked` on the same edge; that first frame 0x7E is delivered.
